ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_sequencer_pkg.sv | 29 ++
 rtl/sign_extend.sv | 26 ++
 rtl/ctrl_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_sequencer_pkg.sv
// Shared types and encoding constants for the control sequencer and its immediate generator.
package ctrl_sequencer_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } state_e;

    typedef enum logic [1:0] {
        ImmZero,
        ImmI,
        ImmB
    } imm_sel_e;

    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [2:0] F3Add = 3'b000;
    localparam logic [2:0] F3Bne = 3'b001;
    localparam logic [6:0] F7Add = 7'b0000000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

endpackage

// File: rtl/sign_extend.sv
// Immediate generator: builds the sign-extended I- or B-type immediate from an instruction word.
module sign_extend
    import ctrl_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:0]           ir_i,
    input  imm_sel_e              imm_sel_i,
    output logic [DATA_WIDTH-1:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (imm_sel_i)
            ImmI:    imm_o = {{(DATA_WIDTH - 12){ir_i[31]}}, ir_i[31:20]};
            ImmB:    imm_o = {{(DATA_WIDTH - 13){ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25],
                              ir_i[11:8], 1'b0};
            default: imm_o = '0;
        endcase
    end

    // Opcode, funct3 and rs1 fields never contribute to an immediate.
    logic unused_ir;
    assign unused_ir = ^{ir_i[19:12], ir_i[6:0]};

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller for addi, add and bne.
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int unsigned            ADDRESS_WIDTH  = 5,
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter int unsigned            ALU_CTRL_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [DATA_WIDTH-1:0]     imem_addr,
    input  logic                      imem_valid,
    input  logic [31:0]               imem_rdata,
    input  logic                      eq,
    output logic [ADDRESS_WIDTH-1:0]  rs1,
    output logic [ADDRESS_WIDTH-1:0]  rs2,
    output logic [ADDRESS_WIDTH-1:0]  rd,
    output logic [DATA_WIDTH-1:0]     ImmOp,
    output logic                      ALUsrc,
    output logic [ALU_CTRL_WIDTH-1:0] ALUctrl,
    output logic                      RegWrite,
    output logic                      illegal
);

    state_e                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     pc_q, pc_d;
    logic [31:0]               ir_q, ir_d;
    logic [ADDRESS_WIDTH-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;
    logic                      alusrc_q, alusrc_d;
    logic [ALU_CTRL_WIDTH-1:0] aluctrl_q, aluctrl_d;
    logic                      branch_q, branch_d;
    logic                      illegal_q, illegal_d;

    logic                      dec_legal, dec_branch, dec_alusrc, dec_sub;
    imm_sel_e                  imm_sel;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [DATA_WIDTH-1:0]     pc_plus4, br_next;

    sign_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sign_extend (
        .ir_i     (ir_q),
        .imm_sel_i(imm_sel),
        .imm_o    (imm_ext)
    );

    always_comb begin
        dec_legal  = 1'b0;
        dec_branch = 1'b0;
        dec_alusrc = 1'b0;
        dec_sub    = 1'b0;
        imm_sel    = ImmZero;
        case (ir_q[6:0])
            OpcOpImm: begin
                if (ir_q[14:12] == F3Add) begin
                    dec_legal  = 1'b1;
                    dec_alusrc = 1'b1;
                    imm_sel    = ImmI;
                end
            end
            OpcOp: begin
                if (ir_q[14:12] == F3Add && ir_q[31:25] == F7Add) begin
                    dec_legal = 1'b1;
                end
            end
            OpcBranch: begin
                if (ir_q[14:12] == F3Bne) begin
                    dec_legal  = 1'b1;
                    dec_branch = 1'b1;
                    dec_sub    = 1'b1;
                    imm_sel    = ImmB;
                end
            end
            default: ;
        endcase
    end

    assign pc_plus4 = pc_q + DATA_WIDTH'(4);
    assign br_next  = eq ? pc_plus4 : pc_q + imm_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        alusrc_d  = alusrc_q;
        aluctrl_d = aluctrl_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        case (state_q)
            StFetch: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_legal) begin
                    rs1_d     = ADDRESS_WIDTH'(ir_q[19:15]);
                    rs2_d     = ADDRESS_WIDTH'(ir_q[24:20]);
                    rd_d      = ADDRESS_WIDTH'(ir_q[11:7]);
                    imm_d     = imm_ext;
                    alusrc_d  = dec_alusrc;
                    aluctrl_d = dec_sub ? ALU_CTRL_WIDTH'(ALU_SUB) : ALU_CTRL_WIDTH'(ALU_ADD);
                    branch_d  = dec_branch;
                    state_d   = StExecute;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end
            end
            StExecute: begin
                if (!branch_q) begin
                    state_d = StWriteback;
                end else if (br_next[1]) begin
                    // Misaligned target: stop with the PC still pointing at the branch.
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    pc_d    = br_next;
                    state_d = StFetch;
                end
            end
            StWriteback: begin
                pc_d    = pc_plus4;
                state_d = StFetch;
            end
            StHalt:  ;
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            alusrc_q  <= 1'b0;
            aluctrl_q <= '0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            alusrc_q  <= alusrc_d;
            aluctrl_q <= aluctrl_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_req  = (state_q == StFetch);
    assign imem_addr = pc_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign ImmOp     = imm_q;
    assign ALUsrc    = alusrc_q;
    assign ALUctrl   = aluctrl_q;
    assign RegWrite  = (state_q == StWriteback) && (rd_q != '0);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with a queue of expected per-instruction results.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        eq;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ImmOp;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic        RegWrite;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alusrc;
        logic [2:0]  aluctrl;
        int          rw;
        logic [31:0] next_pc;
        int          lat;
        logic        halt;
    } exp_t;

    exp_t sb[$];

    ctrl_sequencer #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .ALU_CTRL_WIDTH(3),
        .RESET_PC      (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_valid(imem_valid),
        .imem_rdata(imem_rdata),
        .eq        (eq),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .ImmOp     (ImmOp),
        .ALUsrc    (ALUsrc),
        .ALUctrl   (ALUctrl),
        .RegWrite  (RegWrite),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_instr(input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                                input logic [4:0] e_rd, input logic [31:0] e_imm,
                                input logic e_alusrc, input logic [2:0] e_aluctrl,
                                input int e_rw, input logic [31:0] e_next, input int e_lat,
                                input logic e_halt);
        exp_t e;
        e.rs1 = e_rs1; e.rs2 = e_rs2; e.rd = e_rd; e.imm = e_imm;
        e.alusrc = e_alusrc; e.aluctrl = e_aluctrl; e.rw = e_rw;
        e.next_pc = e_next; e.lat = e_lat; e.halt = e_halt;
        sb.push_back(e);
    endtask

    // Called at a negedge with the DUT in FETCH; returns at a negedge.
    task automatic run_instr(input string name, input logic [31:0] instr, input logic eqv,
                             input int stall, input logic [31:0] pc);
        exp_t        e;
        int          rw_cnt = 0;
        int          lat = 0;
        logic [4:0]  o_rs1 = '0, o_rs2 = '0, o_rd = '0;
        logic [31:0] o_imm = '0;
        logic        o_alusrc = 1'b0;
        logic [2:0]  o_aluctrl = '0;
        e = sb.pop_front();
        chk({name, " req"}, 32'(imem_req), 32'd1);
        chk({name, " addr"}, imem_addr, pc);
        for (int s = 0; s < stall; s++) begin
            imem_valid = 1'b0;
            @(negedge clk);
            chk({name, " stall req"}, 32'(imem_req), 32'd1);
            chk({name, " stall addr"}, imem_addr, pc);
            chk({name, " stall rw"}, 32'(RegWrite), 32'd0);
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Garbage response outside FETCH must be ignored.
                imem_rdata = 32'hFFFF_FFFF;
                eq         = eqv;
            end
            if (c == 2) begin
                o_rs1 = rs1; o_rs2 = rs2; o_rd = rd; o_imm = ImmOp;
                o_alusrc = ALUsrc; o_aluctrl = ALUctrl;
                imem_valid = 1'b0;
            end
            if (RegWrite) rw_cnt++;
            if (imem_req) begin
                lat = c;
                break;
            end
        end
        chk({name, " latency"}, 32'(lat), 32'(e.lat));
        chk({name, " regwrite pulses"}, 32'(rw_cnt), 32'(e.rw));
        chk({name, " next addr"}, imem_addr, e.next_pc);
        chk({name, " illegal"}, 32'(illegal), 32'(e.halt));
        if (!e.halt) begin
            chk({name, " rs1"}, 32'(o_rs1), 32'(e.rs1));
            chk({name, " rs2"}, 32'(o_rs2), 32'(e.rs2));
            chk({name, " rd"}, 32'(o_rd), 32'(e.rd));
            chk({name, " ImmOp"}, o_imm, e.imm);
            chk({name, " ALUsrc"}, 32'(o_alusrc), 32'(e.alusrc));
            chk({name, " ALUctrl"}, 32'(o_aluctrl), 32'(e.aluctrl));
        end
    endtask

    task automatic do_reset(input string name);
        rst        = 1'b1;
        imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({name, " rst addr"}, imem_addr, 32'h0);
        chk({name, " rst illegal"}, 32'(illegal), 32'd0);
        chk({name, " rst rw"}, 32'(RegWrite), 32'd0);
        chk({name, " rst regs"}, 32'({rs1, rs2, rd, ALUsrc, ALUctrl}), 32'd0);
        chk({name, " rst ImmOp"}, ImmOp, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk({name, " first req"}, 32'(imem_req), 32'd1);
    endtask

    initial begin
        int rw_cnt;
        rst        = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = '0;
        eq         = 1'b0;
        do_reset("init");

        expect_instr(5'd0, 5'd5, 5'd10, 32'd5, 1'b1, 3'b000, 1, 32'd4, 4, 1'b0);
        run_instr("addi x10", 32'h0050_0513, 1'b0, 0, 32'd0);

        expect_instr(5'd10, 5'd11, 5'd10, 32'd0, 1'b0, 3'b000, 1, 32'd8, 4, 1'b0);
        run_instr("add", 32'h00B5_0533, 1'b0, 0, 32'd4);

        expect_instr(5'd10, 5'd0, 5'd29, 32'hFFFF_FFFC, 1'b0, 3'b001, 0, 32'd4, 3, 1'b0);
        run_instr("bne taken", 32'hFE05_1EE3, 1'b0, 0, 32'd8);

        expect_instr(5'd10, 5'd11, 5'd10, 32'd0, 1'b0, 3'b000, 1, 32'd8, 4, 1'b0);
        run_instr("add stalled", 32'h00B5_0533, 1'b0, 3, 32'd4);

        expect_instr(5'd10, 5'd0, 5'd29, 32'hFFFF_FFFC, 1'b0, 3'b001, 0, 32'd12, 3, 1'b0);
        run_instr("bne not taken", 32'hFE05_1EE3, 1'b1, 0, 32'd8);

        expect_instr(5'd0, 5'd1, 5'd0, 32'd1, 1'b1, 3'b000, 0, 32'd16, 4, 1'b0);
        run_instr("addi x0", 32'h0010_0013, 1'b0, 0, 32'd12);

        // bne x0,x0,+2: target bit 1 set, PC must stay put.
        expect_instr(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 3'b000, 0, 32'd16, 0, 1'b1);
        run_instr("bne misaligned", 32'h0000_1163, 1'b0, 0, 32'd16);

        do_reset("after misaligned");

        expect_instr(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 3'b000, 0, 32'd0, 0, 1'b1);
        run_instr("zero word", 32'h0000_0000, 1'b0, 0, 32'd0);
        chk("halt req", 32'(imem_req), 32'd0);

        do_reset("after halt");

        // Abort an addi in EXECUTE: no write pulse may follow.
        imem_valid = 1'b1;
        imem_rdata = 32'h0050_0513;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        rw_cnt = 0;
        @(negedge clk);
        if (RegWrite) rw_cnt++;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (RegWrite) rw_cnt++;
        end
        chk("abort rw", 32'(rw_cnt), 32'd0);
        chk("abort addr", imem_addr, 32'h0);
        chk("abort req", 32'(imem_req), 32'd1);
        chk("abort ImmOp", ImmOp, 32'h0);
        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
